max_pooling_fprop2_window_max: RTL

Streaming window-reduction stage directly downstream of the max-pooling index multiplier. The multiplier's 17-bit signed product is used as the element address for the feature-map read. This block receives each fetched element together with that address, one window at a time. It emits the window maximum and the address where the maximum was found. The result feeds the pooled-output write-back and the argmax store used by back-propagation.

---
 rtl/max_pooling_fprop2_window_max.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/max_pooling_fprop2_window_max.sv
// -----------------------------------------------------------------------------
// max_pooling_fprop2_window_max
//
// Streaming window reduction placed after the max-pooling index multiplier.
// Each accepted element (signed value plus its feature-map address) is folded
// into a running maximum. When the last element of a window is accepted, the
// winner goes straight into the output register, which feeds the pooled-output
// write-back and the argmax store used by back-propagation.
//
// Ports
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   win_size              elements per window (0 is treated as 1), sampled on
//                         the first element of each window
//   in_data/in_addr       element value / address, in_valid/in_ready handshake
//   out_max/out_addr      window maximum / address of the first occurrence,
//                         out_valid/out_ready handshake
//   busy                  a window is partially accumulated
//   win_done              free-running count of emitted results (wraps)
// -----------------------------------------------------------------------------
module max_pooling_fprop2_window_max #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 17,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic [CNT_WIDTH-1:0]         win_size,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_max,
    output logic [ADDR_WIDTH-1:0]        out_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [15:0]                  win_done
);

    logic [CNT_WIDTH-1:0]         elem_cnt_q, elem_cnt_d;
    logic [CNT_WIDTH-1:0]         size_q, size_d;
    logic signed [DATA_WIDTH-1:0] acc_max_q, acc_max_d;
    logic [ADDR_WIDTH-1:0]        acc_addr_q, acc_addr_d;
    logic signed [DATA_WIDTH-1:0] out_max_q, out_max_d;
    logic [ADDR_WIDTH-1:0]        out_addr_q, out_addr_d;
    logic                         out_valid_q, out_valid_d;
    logic [15:0]                  win_done_q, win_done_d;
    logic                         busy_q, busy_d;

    logic                         accept;
    logic                         first_elem;
    logic                         last_elem;
    logic                         take_new;
    logic [CNT_WIDTH-1:0]         eff_size;
    logic signed [DATA_WIDTH-1:0] cand_max;
    logic [ADDR_WIDTH-1:0]        cand_addr;

    // Only an unconsumed result blocks the input side.
    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        first_elem = (elem_cnt_q == '0);
        // The live win_size only matters on the first element; afterwards the
        // sampled size governs so mid-window changes are ignored.
        if (first_elem) begin
            eff_size = (win_size == '0) ? CNT_WIDTH'(1) : win_size;
        end else begin
            eff_size = size_q;
        end
        last_elem = (elem_cnt_q == (eff_size - CNT_WIDTH'(1)));
        // Strict compare keeps the earliest address on ties.
        take_new  = first_elem || (in_data > acc_max_q);
        cand_max  = take_new ? in_data : acc_max_q;
        cand_addr = take_new ? in_addr : acc_addr_q;
    end

    always_comb begin
        elem_cnt_d  = elem_cnt_q;
        size_d      = size_q;
        acc_max_d   = acc_max_q;
        acc_addr_d  = acc_addr_q;
        out_max_d   = out_max_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        win_done_d  = win_done_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (first_elem) begin
                size_d = eff_size;
            end
            acc_max_d  = cand_max;
            acc_addr_d = cand_addr;
            if (last_elem) begin
                // A new result in the same cycle as a handshake keeps
                // out_valid high and replaces the register contents.
                out_max_d   = cand_max;
                out_addr_d  = cand_addr;
                out_valid_d = 1'b1;
                elem_cnt_d  = '0;
                win_done_d  = win_done_q + 16'd1;
            end else begin
                elem_cnt_d = elem_cnt_q + CNT_WIDTH'(1);
            end
        end

        busy_d = (elem_cnt_d != '0);
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            elem_cnt_q  <= '0;
            size_q      <= '0;
            acc_max_q   <= '0;
            acc_addr_q  <= '0;
            out_max_q   <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            win_done_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            elem_cnt_q  <= elem_cnt_d;
            size_q      <= size_d;
            acc_max_q   <= acc_max_d;
            acc_addr_q  <= acc_addr_d;
            out_max_q   <= out_max_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            win_done_q  <= win_done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_max   = out_max_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign win_done  = win_done_q;
    assign busy      = busy_q;

endmodule
